// File: rtl/fix_order_extractor_if.sv
// Interface for the FIX order extractor: byte stream in, order records out.
// The slave modport is the extractor's view, the master modport is the view of
// whatever feeds it bytes and consumes its records.
interface fix_order_extractor_if #(
  parameter int PRICE_W   = 64,
  parameter int QTY_W     = 64,
  parameter int OID_W     = 32,
  parameter int SYM_CHARS = 6
);
  logic [7:0]             data_in;
  logic                   valid_in;
  logic                   packet_done;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_msg_type;
  logic [8*SYM_CHARS-1:0] out_symbol;
  logic                   out_side;
  logic [PRICE_W-1:0]     out_price;
  logic [QTY_W-1:0]       out_qty;
  logic [OID_W-1:0]       out_order_id;
  logic [15:0]            drop_count;
  logic                   overflow;

  modport master (
    output data_in, valid_in, packet_done, out_ready,
    input  out_valid, out_msg_type, out_symbol, out_side, out_price,
           out_qty, out_order_id, drop_count, overflow
  );

  modport slave (
    input  data_in, valid_in, packet_done, out_ready,
    output out_valid, out_msg_type, out_symbol, out_side, out_price,
           out_qty, out_order_id, drop_count, overflow
  );
endinterface

// File: rtl/fix_order_extractor.sv
// Streaming FIX tag=value decoder. Parses New (35=D) and Cancel (35=F) orders
// byte by byte, verifies the tag 10 checksum and required fields, and queues
// good records in a small valid/ready FIFO. Discarded messages are counted.
module fix_order_extractor #(
  parameter int PRICE_W    = 64,
  parameter int QTY_W      = 64,
  parameter int OID_W      = 32,
  parameter int SYM_CHARS  = 6,
  parameter int FIFO_DEPTH = 4,
  parameter bit CHECK_SUM  = 1'b1
) (
  input logic clk,
  input logic rst,
  fix_order_extractor_if.slave bus
);

  localparam logic [7:0] SOH   = 8'h01;
  localparam logic [7:0] EQ    = 8'h3D;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam int         AW    = $clog2(FIFO_DEPTH);
  localparam int         SYM_W = 8 * SYM_CHARS;
  localparam int         IDX_W = $clog2(SYM_CHARS + 1);

  typedef enum logic [1:0] {TAG, VALUE, SKIP} state_t;

  typedef struct packed {
    logic               msg_type;
    logic [SYM_W-1:0]   symbol;
    logic               side;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
    logic [OID_W-1:0]   oid;
  } rec_t;

  state_t state, state_next;

  logic [15:0]        tag;
  logic               tag_start;
  logic [7:0]         sum;
  logic [7:0]         snap;
  logic [9:0]         recv_cs;
  logic               err, unsup, in_msg;
  logic               msg_type, side;
  logic               seen35, seen54, seen44, seen38, seen11;
  logic [SYM_W-1:0]   sym;
  logic [IDX_W-1:0]   sym_idx;
  logic [PRICE_W-1:0] price;
  logic [QTY_W-1:0]   qty;
  logic [OID_W-1:0]   oid;

  rec_t             mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [15:0]      drop_count;
  logic             overflow;

  logic [7:0]  d;
  logic        is_digit;
  logic [3:0]  digit;
  logic [19:0] tag_calc;
  logic        set_err, set_unsup, commit, cs_ok, req_ok, good;
  logic        full, pop, push, lost, partial_drop, drop_inc, clear;

  assign d        = bus.data_in;
  assign is_digit = (d >= 8'h30) && (d <= 8'h39);
  assign digit    = d[3:0];
  assign tag_calc = {4'd0, tag} * 20'd10 + {16'd0, digit};

  // Next-state decode, field validation and commit/drop decisions
  always_comb begin
    state_next   = state;
    set_err      = 1'b0;
    set_unsup    = 1'b0;
    commit       = 1'b0;
    cs_ok        = 1'b0;
    req_ok       = 1'b0;
    good         = 1'b0;
    full         = (count == (AW+1)'(FIFO_DEPTH));
    pop          = 1'b0;
    push         = 1'b0;
    lost         = 1'b0;
    partial_drop = 1'b0;
    drop_inc     = 1'b0;
    clear        = 1'b0;
    if (bus.valid_in) begin
      case (state)
        TAG: begin
          if (d == EQ) begin
            state_next = VALUE;
          end else if (!is_digit) begin
            set_err    = 1'b1;
            state_next = SKIP;
          end
        end
        VALUE: begin
          if (d == SOH) begin
            state_next = TAG;
            commit     = (tag == 16'd10);
          end else begin
            case (tag)
              16'd35: set_unsup = !(d == "D" || d == "F");
              16'd54: set_err   = !(d == "1" || d == "2");
              16'd44: set_err   = !(is_digit || d == DOT);
              16'd38, 16'd11, 16'd10: set_err = !is_digit;
              default: ;
            endcase
          end
        end
        default: begin
          if (d == SOH) state_next = TAG;
        end
      endcase
    end
    if (bus.packet_done) state_next = TAG;
    cs_ok  = !CHECK_SUM || (recv_cs == {2'b00, snap});
    req_ok = msg_type ? (seen35 && seen11)
                      : (seen35 && seen54 && seen44 && seen38 && seen11);
    good   = commit && !err && !unsup && cs_ok && req_ok;
    pop    = (count != '0) && bus.out_ready;
    push   = good && (!full || pop);
    lost   = good && !push;
    partial_drop = bus.packet_done && !commit && (in_msg || bus.valid_in);
    drop_inc     = (commit && !good) || lost || partial_drop;
    clear        = commit || bus.packet_done;
  end

  // Parser state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= TAG;
    else      state <= state_next;
  end

  // Per-message datapath: tag, checksum, field accumulators and seen flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      tag       <= '0;
      tag_start <= 1'b1;
      sum       <= '0;
      snap      <= '0;
      recv_cs   <= '0;
      err       <= 1'b0;
      unsup     <= 1'b0;
      in_msg    <= 1'b0;
      msg_type  <= 1'b0;
      side      <= 1'b0;
      seen35    <= 1'b0;
      seen54    <= 1'b0;
      seen44    <= 1'b0;
      seen38    <= 1'b0;
      seen11    <= 1'b0;
      sym       <= {SYM_CHARS{8'h20}};
      sym_idx   <= '0;
      price     <= '0;
      qty       <= '0;
      oid       <= '0;
    end else if (bus.valid_in) begin
      in_msg <= 1'b1;
      sum    <= sum + d;
      if (set_err)   err   <= 1'b1;
      if (set_unsup) unsup <= 1'b1;
      case (state)
        TAG: begin
          if (tag_start) snap <= sum;
          tag_start <= 1'b0;
          if (is_digit) tag <= (tag_calc > 20'd65535) ? 16'hFFFF : tag_calc[15:0];
        end
        VALUE: begin
          if (d == SOH) begin
            case (tag)
              16'd35: seen35 <= 1'b1;
              16'd54: seen54 <= 1'b1;
              16'd44: seen44 <= 1'b1;
              16'd38: seen38 <= 1'b1;
              16'd11: seen11 <= 1'b1;
              default: ;
            endcase
            tag       <= '0;
            tag_start <= 1'b1;
          end else begin
            case (tag)
              16'd35: begin
                if (d == "D") msg_type <= 1'b0;
                if (d == "F") msg_type <= 1'b1;
              end
              16'd55: begin
                if (int'(sym_idx) < SYM_CHARS) begin
                  sym[(SYM_CHARS - 1 - int'(sym_idx)) * 8 +: 8] <= d;
                  sym_idx <= sym_idx + 1'b1;
                end
              end
              16'd54: begin
                if (d == "1") side <= 1'b0;
                if (d == "2") side <= 1'b1;
              end
              16'd44: if (is_digit) price <= price * PRICE_W'(10) + PRICE_W'(digit);
              16'd38: if (is_digit) qty <= qty * QTY_W'(10) + QTY_W'(digit);
              16'd11: if (is_digit) oid <= oid * OID_W'(10) + OID_W'(digit);
              16'd10: if (is_digit) recv_cs <= recv_cs * 10'd10 + {6'd0, digit};
              default: ;
            endcase
          end
        end
        default: begin
          if (d == SOH) begin
            tag       <= '0;
            tag_start <= 1'b1;
          end
        end
      endcase
    end
  end

  // Record FIFO: simultaneous push and pop when full reuses the head slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{msg_type: msg_type, symbol: sym, side: side,
                         price: price, qty: qty, oid: oid};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Drop accounting and overflow pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= lost;
      if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end

  assign bus.out_valid    = (count != '0);
  assign bus.out_msg_type = mem[rd_ptr].msg_type;
  assign bus.out_symbol   = mem[rd_ptr].symbol;
  assign bus.out_side     = mem[rd_ptr].side;
  assign bus.out_price    = mem[rd_ptr].price;
  assign bus.out_qty      = mem[rd_ptr].qty;
  assign bus.out_order_id = mem[rd_ptr].oid;
  assign bus.drop_count   = drop_count;
  assign bus.overflow     = overflow;

endmodule

// File: tb/tb_fix_order_extractor.sv
// Directed bench for fix_order_extractor. A second instance with checksum
// checking disabled shadows the same byte stream.
module tb_fix_order_extractor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fix_order_extractor_if #(.PRICE_W(64), .QTY_W(64), .OID_W(32), .SYM_CHARS(6)) bus ();
  fix_order_extractor_if #(.PRICE_W(64), .QTY_W(64), .OID_W(32), .SYM_CHARS(6)) bus_nc ();

  fix_order_extractor #(.FIFO_DEPTH(4), .CHECK_SUM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  fix_order_extractor #(.FIFO_DEPTH(4), .CHECK_SUM(1'b0)) dut_nc (
    .clk (clk),
    .rst (rst),
    .bus (bus_nc.slave)
  );

  assign bus_nc.data_in     = bus.data_in;
  assign bus_nc.valid_in    = bus.valid_in;
  assign bus_nc.packet_done = bus.packet_done;
  assign bus_nc.out_ready   = 1'b1;

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Drive a string one byte per cycle, '|' standing for SOH
  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte b;
      b = s[i];
      @(negedge clk);
      bus.data_in  = (b == 8'h7C) ? 8'h01 : b;
      bus.valid_in = 1'b1;
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
  endtask

  function automatic int fix_sum(input string s);
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < s.len(); i++) begin
      byte b;
      b = s[i];
      acc += (b == 8'h7C) ? 1 : int'(unsigned'(b));
    end
    return int'(acc % 256);
  endfunction

  task automatic send_msg(input string body, input int cs_delta);
    int cs;
    cs = (fix_sum(body) + cs_delta) % 256;
    applyStimulus({body, $sformatf("10=%03d|", cs)});
  endtask

  initial begin
    string m1;
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    bus.data_in     = 8'h00;
    bus.valid_in    = 1'b0;
    bus.packet_done = 1'b0;
    bus.out_ready   = 1'b1;
    m1 = "8=FIX.4.2|35=D|55=AAPL|54=1|44=150.25|38=100|11=42|";

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_drop_count", 64'(bus.drop_count), 64'd0);
    checkOutput("reset_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("reset_price", bus.out_price, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] new order");
    send_msg(m1, 0);
    checkOutput("new_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("new_type", 64'(bus.out_msg_type), 64'd0);
    checkOutput("new_symbol", 64'(bus.out_symbol), 64'h4141504C2020);
    checkOutput("new_side", 64'(bus.out_side), 64'd0);
    checkOutput("new_price", bus.out_price, 64'd15025);
    checkOutput("new_qty", bus.out_qty, 64'd100);
    checkOutput("new_oid", 64'(bus.out_order_id), 64'd42);
    checkOutput("new_drop", 64'(bus.drop_count), 64'd0);
    @(negedge clk);
    checkOutput("new_popped", 64'(bus.out_valid), 64'd0);

    $display("[TB] bad checksum");
    send_msg(m1, 1);
    checkOutput("badcs_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("badcs_drop", 64'(bus.drop_count), 64'd1);
    checkOutput("nocs_valid", 64'(bus_nc.out_valid), 64'd1);
    checkOutput("nocs_price", bus_nc.out_price, 64'd15025);
    @(negedge clk);

    $display("[TB] cancel");
    send_msg("35=F|11=7|", 0);
    checkOutput("cxl_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("cxl_type", 64'(bus.out_msg_type), 64'd1);
    checkOutput("cxl_oid", 64'(bus.out_order_id), 64'd7);
    @(negedge clk);
    send_msg("35=F|", 0);
    checkOutput("cxl_noid_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("cxl_noid_drop", 64'(bus.drop_count), 64'd2);

    $display("[TB] backpressure and overflow");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_msg($sformatf("35=D|55=MSFT|54=2|44=3.5|38=%0d|11=%0d|", 10 + i, 101 + i), 0);
      checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_head", 64'(bus.out_order_id), 64'd101);
      if (i == 4) begin
        checkOutput("ovf_pulse", 64'(bus.overflow), 64'd1);
        checkOutput("ovf_drop", 64'(bus.drop_count), 64'd3);
      end
    end
    @(negedge clk);
    checkOutput("ovf_cleared", 64'(bus.overflow), 64'd0);
    checkOutput("stall_side", 64'(bus.out_side), 64'd1);
    checkOutput("stall_price", bus.out_price, 64'd35);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("drain_oid", 64'(bus.out_order_id), 64'(101 + i));
      checkOutput("drain_qty", bus.out_qty, 64'(10 + i));
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    checkOutput("drain_empty", 64'(bus.out_valid), 64'd0);

    $display("[TB] packet_done mid-value");
    applyStimulus("35=D|55=X|54=1|44=12");
    bus.packet_done = 1'b1;
    @(negedge clk);
    bus.packet_done = 1'b0;
    checkOutput("pd_drop", 64'(bus.drop_count), 64'd4);
    checkOutput("pd_valid", 64'(bus.out_valid), 64'd0);
    send_msg("8=FIX.4.4|35=D|55=IBMCORPX|54=2|44=0.99|38=7|11=3000000000|", 0);
    checkOutput("pd_next_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("pd_next_symbol", 64'(bus.out_symbol), 64'h49424D434F52);
    checkOutput("pd_next_side", 64'(bus.out_side), 64'd1);
    checkOutput("pd_next_price", bus.out_price, 64'd99);
    checkOutput("pd_next_qty", bus.out_qty, 64'd7);
    checkOutput("pd_next_oid", 64'(bus.out_order_id), 64'd3000000000);
    checkOutput("pd_next_drop", 64'(bus.drop_count), 64'd4);
    @(negedge clk);

    $display("[TB] async reset mid-message");
    bus.out_ready = 1'b0;
    send_msg("35=F|11=1|", 0);
    send_msg("35=F|11=2|", 0);
    checkOutput("rq_valid", 64'(bus.out_valid), 64'd1);
    applyStimulus("35=D|55=Z");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_drop", 64'(bus.drop_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    send_msg(m1, 0);
    checkOutput("post_rst_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("post_rst_price", bus.out_price, 64'd15025);
    checkOutput("post_rst_oid", 64'(bus.out_order_id), 64'd42);
    checkOutput("post_rst_drop", 64'(bus.drop_count), 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
